// File: rtl/l1_mem_flush_pkg.sv
// Shared L1 flush definitions: sweep FSM states and default
// geometry of the flush read-out interface.
package l1_mem_flush_pkg;

    localparam int unsigned FLUSH_WIDTH = 32;
    localparam int unsigned FLUSH_DEPTH = 1024;

    typedef enum logic [2:0] {
        FL_IDLE,
        FL_RD,
        FL_CAP,
        FL_OUT,
        FL_CLR,
        FL_DONE
    } flush_state_e;

endpackage

// File: rtl/l1_mem_flush.sv
// L1 flush/dump engine: walks every SRAM address, streams each word with
// its index over out_valid/out_ready, and optionally zeroes it afterwards.
// Ports: CLK/RST_N; flush_req/flush_clear start a sweep; busy/done report
// progress; out_* is the word stream; mem_* drives the l1_ld_mem wrapper.
module l1_mem_flush
    import l1_mem_flush_pkg::*;
#(
    parameter  int unsigned WIDTH = FLUSH_WIDTH,
    parameter  int unsigned DEPTH = FLUSH_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             flush_req,
    input  logic             flush_clear,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_addr,
    input  logic             mem_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    flush_state_e    state_r;
    logic [AW-1:0]   cnt_r;
    logic            clr_r;
    logic            last;
    logic [AW-1:0]   cnt_inc;

    // The sweep stops at the top entry instead of wrapping.
    assign last      = (cnt_r == AW'(DEPTH - 1));
    assign cnt_inc   = cnt_r + AW'(1);
    assign mem_wdata = '0;

    // Outputs are registered: each transition loads the values the
    // destination state presents, so mem_* is glitch-free at the SRAM.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r   <= FL_IDLE;
            cnt_r     <= '0;
            clr_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            unique case (state_r)
                FL_IDLE: begin
                    // A request before the init sweep ends is held off,
                    // not dropped: it is taken once mem_ready rises.
                    if (flush_req && mem_ready) begin
                        cnt_r    <= '0;
                        clr_r    <= flush_clear;
                        busy     <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        state_r  <= FL_RD;
                    end
                end
                FL_RD: begin
                    mem_en  <= 1'b0;
                    state_r <= FL_CAP;
                end
                FL_CAP: begin
                    // Registering the word here frees RDATA from holding.
                    out_data  <= mem_rdata;
                    out_addr  <= cnt_r;
                    out_valid <= 1'b1;
                    state_r   <= FL_OUT;
                end
                FL_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (clr_r) begin
                            mem_en   <= 1'b1;
                            mem_we   <= 1'b1;
                            mem_addr <= cnt_r;
                            state_r  <= FL_CLR;
                        end else if (last) begin
                            done    <= 1'b1;
                            state_r <= FL_DONE;
                        end else begin
                            cnt_r    <= cnt_inc;
                            mem_en   <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= cnt_inc;
                            state_r  <= FL_RD;
                        end
                    end
                end
                FL_CLR: begin
                    mem_we <= 1'b0;
                    if (last) begin
                        mem_en  <= 1'b0;
                        done    <= 1'b1;
                        state_r <= FL_DONE;
                    end else begin
                        cnt_r    <= cnt_inc;
                        mem_en   <= 1'b1;
                        mem_addr <= cnt_inc;
                        state_r  <= FL_RD;
                    end
                end
                FL_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= FL_IDLE;
                end
                default: begin
                    state_r <= FL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_flush.sv
// Directed bench for l1_mem_flush with DEPTH=8 and a one-cycle-latency
// SRAM model preloaded with word i = 0xA0+i.
module tb_l1_mem_flush;

    localparam int W = 32;
    localparam int D = 8;

    logic          CLK;
    logic          RST_N;
    logic          flush_req;
    logic          flush_clear;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [2:0]    out_addr;
    logic          mem_ready;
    logic          mem_en;
    logic          mem_we;
    logic [2:0]    mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;

    l1_mem_flush #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .flush_req  (flush_req),
        .flush_clear(flush_clear),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .mem_ready  (mem_ready),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // SRAM model
    logic [W-1:0] mem [D];
    logic         preload;
    int           wr_cnt = 0;
    int           wr_viol = 0;
    int           last_hs = -1;

    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < D; i++) mem[i] <= 32'(32'hA0 + i);
        end else if (mem_en) begin
            if (mem_we) begin
                if (int'(mem_addr) != last_hs || mem_wdata != '0)
                    wr_viol <= wr_viol + 1;
                wr_cnt <= wr_cnt + 1;
                mem[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    // Stream monitor
    logic [2:0]   hs_addr [256];
    logic [W-1:0] hs_data [256];
    int           hs_cnt = 0;
    int           stall_viol = 0;
    int           stab_viol = 0;
    int           done_cnt = 0;
    int           en_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic [2:0]   prev_addr;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stall <= 1'b0;
        end else begin
            if (out_valid && out_ready && hs_cnt < 256) begin
                hs_addr[hs_cnt] <= out_addr;
                hs_data[hs_cnt] <= out_data;
                hs_cnt          <= hs_cnt + 1;
                last_hs         <= int'(out_addr);
            end
            if (out_valid && !out_ready && mem_en)
                stall_viol <= stall_viol + 1;
            if (prev_stall &&
                (!out_valid || out_data != prev_data || out_addr != prev_addr))
                stab_viol <= stab_viol + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (mem_en) en_cnt <= en_cnt + 1;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_addr  <= out_addr;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_preload();
        @(posedge CLK); #1 preload = 1'b1;
        @(posedge CLK); #1 preload = 1'b0;
    endtask

    task automatic wait_done(output int cyc, input bit rnd);
        cyc = 1;
        while (!done && cyc < 400) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    typedef struct {
        logic clr;
        logic rnd;
        int   exp_done;
    } vec_t;

    task automatic run_sweep(input vec_t v);
        int hs0, st0, sb0, wv0, wc0, d0, cyc;
        do_preload();
        hs0 = hs_cnt; st0 = stall_viol; sb0 = stab_viol;
        wv0 = wr_viol; wc0 = wr_cnt; d0 = done_cnt;
        flush_clear = v.clr;
        flush_req   = 1'b1;
        out_ready   = 1'b1;
        @(posedge CLK); #1;
        flush_req   = 1'b0;
        flush_clear = 1'b0;
        wait_done(cyc, v.rnd);
        if (v.exp_done != 0) chk("done_cycle", 64'(cyc), 64'(v.exp_done));
        out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("word_count", 64'(hs_cnt - hs0), 64'(D));
        for (int i = 0; i < D; i++) begin
            chk("word_addr", 64'(hs_addr[hs0 + i]), 64'(i));
            chk("word_data", 64'(hs_data[hs0 + i]), 64'(32'hA0 + i));
            chk("mem_after", 64'(mem[i]), v.clr ? 64'd0 : 64'(32'hA0 + i));
        end
        chk("stall_mem_en", 64'(stall_viol - st0), 64'd0);
        chk("stall_stable", 64'(stab_viol - sb0), 64'd0);
        chk("write_order", 64'(wr_viol - wv0), 64'd0);
        chk("write_count", 64'(wr_cnt - wc0), v.clr ? 64'(D) : 64'd0);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    endtask

    vec_t vecs [4];

    initial begin
        int cyc, d0, e0, wc0;
        vecs[0] = '{clr: 1'b0, rnd: 1'b0, exp_done: 25};
        vecs[1] = '{clr: 1'b1, rnd: 1'b0, exp_done: 33};
        vecs[2] = '{clr: 1'b0, rnd: 1'b1, exp_done: 0};
        vecs[3] = '{clr: 1'b1, rnd: 1'b1, exp_done: 0};

        RST_N = 1'b0; flush_req = 1'b0; flush_clear = 1'b0;
        out_ready = 1'b1; mem_ready = 1'b1; preload = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        @(posedge CLK); #1 RST_N = 1'b1;

        for (int k = 0; k < 4; k++) run_sweep(vecs[k]);

        // Reset mid-OUT aborts the sweep with no done pulse
        do_preload();
        out_ready = 1'b0;
        flush_req = 1'b1;
        @(posedge CLK); #1 flush_req = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge CLK); #1; cyc++;
        end
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_addr", 64'(out_addr), 64'd0);
        chk("stall_data", 64'(out_data), 64'hA0);
        d0 = done_cnt;
        @(posedge CLK); #2 RST_N = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_data", 64'(out_data), 64'd0);
        chk("abort_mem_en", 64'(mem_en), 64'd0);
        @(posedge CLK); #1 RST_N = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin @(posedge CLK); #1; end
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        // Request held off until the init sweep finishes
        mem_ready = 1'b0;
        flush_req = 1'b1;
        e0 = en_cnt;
        repeat (20) begin @(posedge CLK); #1; end
        chk("gate_no_en", 64'(en_cnt - e0), 64'd0);
        chk("gate_not_busy", 64'(busy), 64'd0);
        mem_ready = 1'b1;
        @(posedge CLK); #1;
        flush_req = 1'b0;
        chk("gate_busy", 64'(busy), 64'd1);
        chk("gate_rd_en", 64'(mem_en), 64'd1);
        chk("gate_rd_addr", 64'(mem_addr), 64'd0);
        wait_done(cyc, 1'b0);
        @(posedge CLK); #1;

        // Requests while busy and in the DONE cycle are ignored
        do_preload();
        d0 = done_cnt; wc0 = wr_cnt;
        flush_req = 1'b1;
        @(posedge CLK); #1 flush_req = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            if (cyc == 10) begin flush_req = 1'b1; flush_clear = 1'b1; end
            if (cyc == 11) begin flush_req = 1'b0; flush_clear = 1'b0; end
            @(posedge CLK); #1; cyc++;
        end
        chk("busy_req_done_cycle", 64'(cyc), 64'd25);
        flush_req = 1'b1; flush_clear = 1'b1;
        @(posedge CLK); #1;
        flush_req = 1'b0; flush_clear = 1'b0;
        chk("done_req_ignored", 64'(busy), 64'd0);
        @(posedge CLK); #1;
        chk("still_idle", 64'(busy), 64'd0);
        chk("one_done", 64'(done_cnt - d0), 64'd1);
        chk("no_clear_writes", 64'(wr_cnt - wc0), 64'd0);
        for (int i = 0; i < D; i++)
            chk("mem_intact", 64'(mem[i]), 64'(32'hA0 + i));
        run_sweep(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_mem_flush.md
# l1_mem_flush

Sequential read-out engine for an L1 data/tag array built on `l1_ld_mem`, the reader counterpart to that block's reset-time write sweep. On request it walks every address of the single-port SRAM and streams each word, with its index, out on a valid/ready interface. With clear mode selected, it also zeroes each entry after that entry's handshake completes. It sits between the L1 controller (flush/dump request) and the memory wrapper's EN/WE/ADDR/WDATA/RDATA/ready ports; the controller muxes the wrapper's ports to this block while `busy` is high.

## Interface
Parameters:
- WIDTH, 32, data word width; must match the attached memory.
- DEPTH, 1024, number of entries; power of two; AW = $clog2(DEPTH).

Ports:
- CLK  in  1  clock; all logic rises on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- flush_req  in  1  start pulse or level; sampled only in IDLE.
- flush_clear  in  1  clear mode; sampled together with flush_req.
- busy  out  1  high from the cycle after acceptance through DONE.
- done  out  1  one-cycle pulse after the last word is handled.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIDTH  captured memory word.
- out_addr  out  AW  index of out_data.
- mem_ready  in  1  `ready` from the memory wrapper; init sweep finished.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  AW  SRAM address.
- mem_wdata  out  WIDTH  SRAM write data; always zero.
- mem_rdata  in  WIDTH  SRAM read data.

## Operation
State machine: IDLE, RD, CAP, OUT, CLR, DONE. One address counter `cnt_r` (AW bits) and one clear-mode flag `clr_r`.

- **IDLE**
  - Condition: flush_req && mem_ready.
  - Action: cnt_r<=0, clr_r<=flush_clear, go RD.
  - flush_req while mem_ready=0 is held off and not dropped; it is accepted when mem_ready rises if still asserted.
- **RD**
  - Drive mem_en=1, mem_we=0, mem_addr=cnt_r.
  - Go CAP.
- **CAP**
  - Capture: data_r<=mem_rdata, addr_r<=cnt_r.
  - Go OUT.
- **OUT**
  - Drive out_valid=1. out_data and out_addr are stable until the handshake.
  - Handshake is out_valid && out_ready.
  - On handshake: go CLR if clr_r, otherwise do NEXT.
- **CLR**
  - Drive mem_en=1, mem_we=1, mem_addr=cnt_r, mem_wdata=0.
  - Then do NEXT.
- **NEXT** (a transition, not a state)
  - If cnt_r==DEPTH-1, go DONE.
  - Otherwise cnt_r<=cnt_r+1 and go RD.
  - The counter never wraps inside a sweep.
- **DONE**
  - Drive done=1 for exactly one cycle.
  - Go IDLE.

Additional rules:
- mem_en=0 in IDLE, CAP, OUT and DONE.
- mem_we=1 only in CLR.
- flush_req and flush_clear are ignored outside IDLE.
- out_valid is never deasserted before its handshake.
- busy=1 in every state except IDLE.

## Timing
Reset values (asynchronous): state=IDLE; busy, done, out_valid, mem_en, mem_we = 0; out_data, out_addr, mem_addr, cnt_r, clr_r = 0.

Latency and throughput:
- flush_req accepted at edge 0: RD is cycle 1, CAP is cycle 2, out_valid first high in cycle 3.
- SRAM read latency is one cycle; the word is registered in CAP, so RDATA does not need to hold.
- With out_ready tied high:
  - per word: 3 cycles (no clear) or 4 cycles (clear);
  - total busy cycles: 3·DEPTH+1 (no clear) or 4·DEPTH+1 (clear).
- done is asserted in the cycle after the last handshake (no clear) or after the last CLR.

Boundary conditions:
- out_ready low stalls indefinitely in OUT; no memory access occurs during a stall.
- A write to an entry never precedes the read-out and handshake of that entry.
- flush_req in the same cycle as DONE is ignored; a new request is accepted one cycle later in IDLE.
- Asserting RST_N low mid-sweep aborts the sweep. Outputs return to their reset values asynchronously and no done pulse is produced. Partially cleared contents are the system's concern.

## Structure
- Shared L1 package holds the state enum (IDLE/RD/CAP/OUT/CLR/DONE) and the flush-interface width constants.
- Single module; no sub-module. The SRAM stays in `l1_ld_mem`, connected externally.

## Test plan
- **Reset:** RST_N low mid-OUT → all outputs 0 immediately; after release state=IDLE, no done pulse.
- **Plain dump:** DEPTH=8, memory preloaded with word i = 0xA0+i, flush_clear=0, out_ready=1 → 8 words with out_addr 0..7 and data 0xA0..0xA7; done at cycle 25 after acceptance; memory unchanged.
- **Clear dump:** same preload, flush_clear=1 → same 8 words; every entry reads 0 afterwards; done at cycle 33; each write at address i occurs after word i's handshake.
- **Backpressure:** out_ready toggled randomly → out_data/out_addr stable while valid&&!ready; no mem_en during stalls; no loss or duplication.
- **Init gating:** flush_req held while mem_ready=0 for 20 cycles → no mem_en until mem_ready rises; the sweep starts the cycle after.
- **Requests while busy:** flush_req pulsed mid-sweep and in the DONE cycle → ignored; exactly one done pulse; a fresh request afterwards runs a full second sweep.
